// File: rtl/song_player_seq.sv
// song_player_seq
// Note sequencer for the music player. Walks a song stored in an external
// registered ROM of {note, duration} words, counts each note's duration in
// beat strobes and presents the current note code to the tone generator.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   play       level: 1 = run/resume, 0 = pause (or stay idle)
//   restart    pulse: abort the current song, return to IDLE
//   song_sel   song number, sampled only when leaving IDLE
//   loop_en    1 = replay from index 0 at end of song
//   beat       one-cycle strobe per duration unit
//   rom_addr   {song, index} to the ROM
//   rom_data   {note, duration}, valid one cycle after rom_addr changes
//   note       current note code (0 = rest / not sounding)
//   note_en    note actively sounding and not paused
//   new_note   one-cycle pulse when note loads a new entry
//   song_done  one-cycle pulse in the cycle the end of song is taken
//   busy       high in every state except IDLE and DONE
module song_player_seq #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 7,
  parameter int SONG_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       play,
  input  logic                       restart,
  input  logic [SONG_W-1:0]          song_sel,
  input  logic                       loop_en,
  input  logic                       beat,
  output logic [SONG_W+IDX_W-1:0]    rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]    rom_data,
  output logic [NOTE_W-1:0]          note,
  output logic                       note_en,
  output logic                       new_note,
  output logic                       song_done,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                new_note_q, new_note_d;
  logic                done_d;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      song_q     <= '0;
      cnt_q      <= '0;
      note_q     <= '0;
      new_note_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      song_q     <= song_d;
      cnt_q      <= cnt_d;
      note_q     <= note_d;
      new_note_q <= new_note_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    song_d     = song_q;
    cnt_d      = cnt_q;
    note_d     = note_q;
    new_note_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (play) begin
          song_d  = song_sel;
          state_d = S_FETCH;
        end
      end

      // Address is already on rom_addr; the ROM registers it this cycle.
      S_FETCH: state_d = S_WAIT;

      S_WAIT: begin
        if (rom_dur == '0) begin
          done_d = 1'b1;
          if (loop_en) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            note_d  = '0;
            state_d = S_DONE;
          end
        end else begin
          cnt_d      = rom_dur;
          note_d     = rom_note;
          new_note_d = 1'b1;
          state_d    = S_PLAY;
        end
      end

      S_PLAY: begin
        if (play && beat && (cnt_q != '0)) begin
          cnt_d = cnt_q - DUR_W'(1);
          if (cnt_q == DUR_W'(1)) begin
            if (idx_q != IDX_LAST) begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_FETCH;
            end else begin
              // Last slot of the song area: end is forced, index never wraps.
              done_d = 1'b1;
              if (loop_en) begin
                idx_d   = '0;
                state_d = S_FETCH;
              end else begin
                note_d  = '0;
                state_d = S_DONE;
              end
            end
          end
        end
      end

      S_DONE: begin
        note_d = '0;
        if (!play) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything in the cycle, including a pending end pulse.
    if (restart) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      cnt_d      = '0;
      note_d     = '0;
      new_note_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign rom_addr  = {song_q, idx_q};
  assign note      = note_q;
  assign new_note  = new_note_q;
  assign song_done = done_d;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign note_en   = (state_q == S_PLAY) && play && (note_q != '0);

endmodule

// File: tb/tb_song_player_seq.sv
module tb_song_player_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        play, restart, loop_en, beat;
  logic [1:0]  song_sel;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic        note_en, new_note, song_done, busy;

  always #5 clk = ~clk;

  song_player_seq #(.NOTE_W(6), .DUR_W(6), .IDX_W(7), .SONG_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .restart(restart),
    .song_sel(song_sel), .loop_en(loop_en), .beat(beat),
    .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
    .note_en(note_en), .new_note(new_note), .song_done(song_done),
    .busy(busy)
  );

  // Registered song ROM
  logic [11:0] rom [0:511];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct { bit is_done; int n; int d; } ev_t;
  ev_t q[$];

  int checks = 0;
  int errors = 0;

  // monitor-visible model state
  bit mon_on = 0;
  bit pending = 0;
  int cur_n = 0, cur_d = 0, cnt = 0;
  bit rst_chk = 0;
  bit loop_wait = 0;
  int last_done_cyc = 0;
  int cyc = 0;
  int exp_song = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected event list for a song, straight from the song rules.
  task automatic push_song(input int s, input int rounds);
    logic [11:0] e;
    ev_t ev;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < 128; i++) begin
        e = rom[s*128 + i];
        if (e[5:0] == 6'd0) begin
          ev.is_done = 1; ev.n = 0; ev.d = 0; q.push_back(ev);
          break;
        end
        ev.is_done = 0; ev.n = int'(e[11:6]); ev.d = int'(e[5:0]);
        q.push_back(ev);
        if (i == 127) begin
          ev.is_done = 1; ev.n = 0; ev.d = 0; q.push_back(ev);
        end
      end
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    ev_t e;
    bit exp_en;
    cyc++;
    if (mon_on) begin
      if (rst_chk) begin
        chk("restart_busy", int'(busy), 0);
        chk("restart_note", int'(note), 0);
        chk("restart_idx", int'(rom_addr[6:0]), 0);
        chk("restart_newnote", int'(new_note), 0);
        rst_chk = 0;
      end
      if (restart) begin
        chk("restart_no_done", int'(song_done), 0);
        q.delete();
        pending = 0;
        loop_wait = 0;
        rst_chk = 1;
      end else begin
        if (new_note) begin
          if (q.size() == 0) begin
            chk("unexpected_new_note", 1, 0);
          end else begin
            e = q.pop_front();
            chk("new_note_kind", int'(e.is_done), 0);
            if (pending) chk("beats_per_note", cnt, cur_d);
            if (loop_wait) begin
              chk("loop_latency", cyc - last_done_cyc, 3);
              loop_wait = 0;
            end
            cur_n = e.n; cur_d = e.d; cnt = 0; pending = 1;
          end
        end
        exp_en = pending && (cnt < cur_d) && play && (cur_n != 0);
        chk("note_en", int'(note_en), int'(exp_en));
        if (pending) chk("note_value", int'(note), cur_n);
        if (!busy) chk("note_idle_zero", int'(note), 0);
        if (busy) chk("rom_song", int'(rom_addr[8:7]), exp_song);
        if (beat && play && pending) cnt++;
        if (song_done) begin
          if (q.size() == 0) begin
            chk("unexpected_song_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("song_done_kind", int'(e.is_done), 1);
            if (pending) chk("beats_last_note", cnt, cur_d);
          end
          pending = 0;
          last_done_cyc = cyc;
          loop_wait = loop_en;
        end
      end
    end
  end

  // Beat source: one-cycle strobes spaced at least 4 cycles apart
  initial begin
    beat = 0;
    forever begin
      @(posedge clk); #1 beat = 1;
      @(posedge clk); #1 beat = 0;
      repeat (2 + $urandom_range(0, 5)) @(posedge clk);
    end
  end

  task automatic wait_empty(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk({name, "_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  task automatic wait_cnt(input int n, input int c, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (pending && cur_n == n && cnt >= c) break;
    end
    if (!(pending && cur_n == n && cnt >= c)) chk("wait_cnt_timeout", cnt, c);
  endtask

  task automatic go_idle();
    #1 play = 0; loop_en = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_restart();
    #1 restart = 1; play = 0; loop_en = 0;
    @(posedge clk); #1 restart = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int len;
    for (int i = 0; i < 512; i++) rom[i] = '0;
    // song 1: fixed
    rom[128] = {6'd5, 6'd3}; rom[129] = {6'd9, 6'd2}; rom[130] = {6'd0, 6'd0};
    // song 3: restart target
    rom[384] = {6'd3, 6'd6}; rom[385] = {6'd4, 6'd2}; rom[386] = {6'd0, 6'd0};
    // song 0: all 128 entries nonzero duration
    for (int i = 0; i < 128; i++)
      rom[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 2))};

    rst_n = 0; play = 0; restart = 0; loop_en = 0; song_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_note", int'(note), 0);
    chk("rst_note_en", int'(note_en), 0);
    chk("rst_new_note", int'(new_note), 0);
    chk("rst_song_done", int'(song_done), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1;
    mon_on = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_rom_addr", int'(rom_addr), 0);
    end

    // Song 1, no loop, with start latency checks
    exp_song = 1; song_sel = 2'd1;
    push_song(1, 1);
    play = 1;
    @(posedge clk); #1;
    chk("fetch_rom_addr", int'(rom_addr), 'h080);
    chk("fetch_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("wait_new_note", int'(new_note), 0);
    @(posedge clk); #1;
    chk("first_new_note", int'(new_note), 1);
    chk("first_note", int'(note), 5);
    wait_empty(2000, "song1");
    #1;
    chk("done_busy", int'(busy), 0);
    chk("done_note", int'(note), 0);
    chk("done_pulse_once", int'(song_done), 0);
    go_idle();

    // Song 1 looping; song_sel change must be ignored
    song_sel = 2'd1; loop_en = 1;
    push_song(1, 3);
    play = 1;
    repeat (3) @(posedge clk);
    #1 song_sel = 2'd2;
    wait_empty(3000, "loop");
    do_restart();

    // Pause after one beat of the first note
    song_sel = 2'd1;
    push_song(1, 1);
    play = 1;
    wait_cnt(5, 1, 500);
    #1 play = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("pause_note", int'(note), 5);
    chk("pause_note_en", int'(note_en), 0);
    play = 1;
    wait_empty(2000, "pause");
    go_idle();

    // Random songs on slot 2: leading rest, random body, random pauses
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(2, 10);
      rom[256] = {6'd0, 6'd4};
      for (int i = 1; i < len; i++)
        rom[256 + i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 4))};
      rom[256 + len] = {6'($urandom_range(0, 63)), 6'd0};
      exp_song = 2; song_sel = 2'd2;
      push_song(2, 1);
      play = 1;
      for (int i = 0; i < 6000; i++) begin
        @(posedge clk);
        if (q.size() == 0) break;
        #1;
        if (play) begin
          if ($urandom_range(0, 19) == 0) play = 0;
        end else if ($urandom_range(0, 7) == 0) play = 1;
      end
      if (q.size() != 0) begin
        chk("random_timeout", q.size(), 0);
        q.delete();
      end
      go_idle();
    end

    // Restart mid-note
    exp_song = 3; song_sel = 2'd3;
    push_song(3, 1);
    play = 1;
    wait_cnt(3, 2, 500);
    do_restart();
    repeat (20) @(posedge clk);

    // Full 128-entry song
    exp_song = 0; song_sel = 2'd0;
    push_song(0, 1);
    play = 1;
    wait_empty(20000, "full");
    #1;
    chk("full_done_busy", int'(busy), 0);
    chk("full_last_idx", int'(rom_addr[6:0]), 127);
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
